// File: rtl/ac_ctrl_pkg.sv
// Shared definitions for the AC operation sequencer: op codes, FSM states,
// unit-select bundle and default widths.
package ac_ctrl_pkg;

  localparam int WIDTH_DEF   = 16;
  localparam int IN_W_DEF    = 8;
  localparam int ADDR_W_DEF  = 12;
  localparam int TIMEOUT_DEF = 15;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_AND = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_LDA = 4'd3;
  localparam logic [3:0] OP_CLA = 4'd4;
  localparam logic [3:0] OP_CLE = 4'd5;
  localparam logic [3:0] OP_CMA = 4'd6;
  localparam logic [3:0] OP_CME = 4'd7;
  localparam logic [3:0] OP_CIR = 4'd8;
  localparam logic [3:0] OP_CIL = 4'd9;
  localparam logic [3:0] OP_INC = 4'd10;
  localparam logic [3:0] OP_INP = 4'd11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_EXEC = 2'd2,
    S_RET  = 2'd3
  } state_e;

  typedef struct packed {
    logic f_and;
    logic f_add;
    logic f_dr0;
    logic f_inpt;
    logic f_com;
    logic f_shl;
    logic f_shr;
  } sel_t;

  // Ops whose operand comes from memory.
  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == OP_AND) || (op == OP_ADD) || (op == OP_LDA);
  endfunction

  function automatic logic is_legal_op(input logic [3:0] op);
    return op <= OP_INP;
  endfunction

  // Unit select for an op; CLA, CLE, CME, NOP and illegal codes select nothing.
  function automatic sel_t op_sel(input logic [3:0] op);
    sel_t s;
    s = '0;
    case (op)
      OP_AND:         s.f_and  = 1'b1;
      OP_ADD, OP_INC: s.f_add  = 1'b1;
      OP_LDA:         s.f_dr0  = 1'b1;
      OP_CMA:         s.f_com  = 1'b1;
      OP_CIR:         s.f_shr  = 1'b1;
      OP_CIL:         s.f_shl  = 1'b1;
      OP_INP:         s.f_inpt = 1'b1;
      default:        s        = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/ac_rd_timer.sv
// Counts RD-state cycles spent waiting for mem_ack; expired flags the cycle
// that would bring the count up to TIMEOUT.
module ac_rd_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end

  logic [CW-1:0] cnt;

  // Clear has priority over counting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expired = en && (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/ac_op_sequencer.sv
// Control sequencer for the AC unit: accepts one op per handshake, fetches
// the memory operand when needed, strobes one unit select for a single cycle
// and writes the unit result back into AC/E.
module ac_op_sequencer
  import ac_ctrl_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int IN_W    = IN_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [WIDTH-1:0]  mem_data,
  output logic              inp_ack,
  output logic              alu_and,
  output logic              alu_add,
  output logic              alu_dr0,
  output logic              alu_inpt,
  output logic              alu_com,
  output logic              alu_shl,
  output logic              alu_shr,
  output logic              alu_e,
  output logic [WIDTH-1:0]  alu_ac,
  output logic [WIDTH-1:0]  alu_dr,
  input  logic [WIDTH-1:0]  alu_acdata,
  input  logic              alu_cout,
  output logic [WIDTH-1:0]  ac,
  output logic              e,
  output logic              ac_zero,
  output logic              ac_neg,
  output logic              done,
  output logic              err
);

  if (IN_W < 1 || IN_W > WIDTH) begin : g_bad_in_w
    $error("IN_W must lie between 1 and WIDTH");
  end

  state_e            state;
  logic [3:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [WIDTH-1:0]  dr;
  logic              err_pend;
  sel_t              sel_q;
  logic              tmr_clr;
  logic              tmr_en;
  logic              rd_expired;

  assign tmr_en  = (state == S_RD) && !mem_ack;
  assign tmr_clr = (state != S_RD) || mem_ack;

  ac_rd_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_rd_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (tmr_clr),
    .en     (tmr_en),
    .expired(rd_expired)
  );

  // Sequencer FSM plus AC/E/DR and all registered strobes. Illegal codes pass
  // through EXEC with no select so every register-class op, legal or not,
  // retires with the same latency. done is raised on the RET->IDLE edge so a
  // new request can be accepted in the same cycle done is seen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      op_q     <= OP_NOP;
      addr_q   <= '0;
      ac       <= '0;
      e        <= 1'b0;
      dr       <= '0;
      err_pend <= 1'b0;
      sel_q    <= '0;
      mem_rd   <= 1'b0;
      inp_ack  <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      sel_q   <= '0;
      inp_ack <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            op_q     <= req_op;
            addr_q   <= req_addr;
            err_pend <= !is_legal_op(req_op);
            if (is_mem_op(req_op)) begin
              mem_rd <= 1'b1;
              state  <= S_RD;
            end else begin
              if (req_op == OP_INC) begin
                dr <= {{(WIDTH-1){1'b0}}, 1'b1};
              end
              sel_q   <= op_sel(req_op);
              inp_ack <= (req_op == OP_INP);
              state   <= S_EXEC;
            end
          end
        end
        S_RD: begin
          if (mem_ack) begin
            dr     <= mem_data;
            mem_rd <= 1'b0;
            sel_q  <= op_sel(op_q);
            state  <= S_EXEC;
          end else if (rd_expired) begin
            mem_rd   <= 1'b0;
            err_pend <= 1'b1;
            state    <= S_RET;
          end
        end
        S_EXEC: begin
          case (op_q)
            OP_AND, OP_LDA, OP_CLA, OP_CMA, OP_INP: begin
              ac <= alu_acdata;
            end
            OP_ADD, OP_INC: begin
              ac <= alu_acdata;
              e  <= alu_cout;
            end
            OP_CIR: begin
              ac <= alu_acdata;
              e  <= ac[0];
            end
            OP_CIL: begin
              ac <= alu_acdata;
              e  <= ac[WIDTH-1];
            end
            OP_CLE: e <= 1'b0;
            OP_CME: e <= ~e;
            default: ;
          endcase
          state <= S_RET;
        end
        S_RET: begin
          done  <= 1'b1;
          err   <= err_pend;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign req_ready = (state == S_IDLE);
  assign mem_addr  = addr_q;

  assign alu_and  = sel_q.f_and;
  assign alu_add  = sel_q.f_add;
  assign alu_dr0  = sel_q.f_dr0;
  assign alu_inpt = sel_q.f_inpt;
  assign alu_com  = sel_q.f_com;
  assign alu_shl  = sel_q.f_shl;
  assign alu_shr  = sel_q.f_shr;

  assign alu_e  = e;
  assign alu_ac = ac;
  assign alu_dr = dr;

  assign ac_zero = (ac == '0);
  assign ac_neg  = ac[WIDTH-1];

endmodule

// File: tb/tb_ac_op_sequencer.sv
// Directed bench for ac_op_sequencer with a behavioural AC unit attached.
module tb_ac_op_sequencer;

  localparam int WIDTH  = 16;
  localparam int IN_W   = 8;
  localparam int ADDR_W = 12;
  localparam int TMO    = 4;

  localparam logic [6:0] S_NONE = 7'b0000000;
  localparam logic [6:0] S_AND  = 7'b1000000;
  localparam logic [6:0] S_ADD  = 7'b0100000;
  localparam logic [6:0] S_DR0  = 7'b0010000;
  localparam logic [6:0] S_INPT = 7'b0001000;
  localparam logic [6:0] S_COM  = 7'b0000100;
  localparam logic [6:0] S_SHL  = 7'b0000010;
  localparam logic [6:0] S_SHR  = 7'b0000001;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic [3:0]        req_op;
  logic [ADDR_W-1:0] req_addr;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [WIDTH-1:0]  mem_data;
  logic              inp_ack;
  logic              alu_and, alu_add, alu_dr0, alu_inpt, alu_com, alu_shl, alu_shr;
  logic              alu_e;
  logic [WIDTH-1:0]  alu_ac;
  logic [WIDTH-1:0]  alu_dr;
  logic [WIDTH-1:0]  alu_acdata;
  logic              alu_cout;
  logic [WIDTH-1:0]  ac;
  logic              e;
  logic              ac_zero;
  logic              ac_neg;
  logic              done;
  logic              err;

  logic [IN_W-1:0]   inpr = 8'hC3;

  int n_asserts = 0;
  int n_fail    = 0;

  int         lat;
  int         rd_cycles;
  int         sel_cycles;
  int         inp_cycles;
  logic [6:0] sel_seen;
  logic       multi;
  logic       got_err;
  logic       addr_bad;

  always #5 clk = ~clk;

  ac_op_sequencer #(
    .WIDTH  (WIDTH),
    .IN_W   (IN_W),
    .ADDR_W (ADDR_W),
    .TIMEOUT(TMO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_data  (mem_data),
    .inp_ack   (inp_ack),
    .alu_and   (alu_and),
    .alu_add   (alu_add),
    .alu_dr0   (alu_dr0),
    .alu_inpt  (alu_inpt),
    .alu_com   (alu_com),
    .alu_shl   (alu_shl),
    .alu_shr   (alu_shr),
    .alu_e     (alu_e),
    .alu_ac    (alu_ac),
    .alu_dr    (alu_dr),
    .alu_acdata(alu_acdata),
    .alu_cout  (alu_cout),
    .ac        (ac),
    .e         (e),
    .ac_zero   (ac_zero),
    .ac_neg    (ac_neg),
    .done      (done),
    .err       (err)
  );

  // Behavioural AC unit: result is zero when no select is active.
  always_comb begin
    alu_acdata = '0;
    alu_cout   = 1'b0;
    if (alu_and)       alu_acdata = alu_ac & alu_dr;
    else if (alu_add)  {alu_cout, alu_acdata} = {1'b0, alu_ac} + {1'b0, alu_dr};
    else if (alu_dr0)  alu_acdata = alu_dr;
    else if (alu_inpt) alu_acdata = {{(WIDTH-IN_W){1'b0}}, inpr};
    else if (alu_com)  alu_acdata = ~alu_ac;
    else if (alu_shr)  alu_acdata = {alu_e, alu_ac[WIDTH-1:1]};
    else if (alu_shl)  alu_acdata = {alu_ac[WIDTH-2:0], alu_e};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_asserts++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op; ack_cyc selects the cycle after acceptance in which mem_ack
  // is driven (0 = never). Records latency and strobe activity.
  task automatic run_op(input logic [3:0] op, input logic [ADDR_W-1:0] addr,
                        input int ack_cyc, input logic [WIDTH-1:0] data);
    logic [6:0] sel;
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    tick();
    req_valid  = 1'b0;
    req_op     = 4'd0;
    lat        = 0;
    rd_cycles  = 0;
    sel_cycles = 0;
    inp_cycles = 0;
    sel_seen   = '0;
    multi      = 1'b0;
    got_err    = 1'b0;
    addr_bad   = 1'b0;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      mem_ack  = (k == ack_cyc);
      mem_data = (k == ack_cyc) ? data : 16'hDEAD;
      sel = {alu_and, alu_add, alu_dr0, alu_inpt, alu_com, alu_shl, alu_shr};
      if (mem_rd) begin
        rd_cycles++;
        if (mem_addr !== addr) addr_bad = 1'b1;
      end
      if (sel != '0) sel_cycles++;
      if ($countones(sel) > 1) multi = 1'b1;
      sel_seen = sel_seen | sel;
      if (inp_ack) inp_cycles++;
      tick();
      mem_ack = 1'b0;
      if (done) begin
        lat     = k;
        got_err = err;
      end
    end
    if (lat == 0) check("op_done_bound", {31'd0, done}, 32'd1);
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_op    = 4'd0;
    req_addr  = '0;
    mem_ack   = 1'b0;
    mem_data  = '0;
    tick();
    tick();
    check("rst_ac", ac, 0);
    check("rst_e", e, 0);
    check("rst_ready", req_ready, 1);
    check("rst_mem_rd", mem_rd, 0);
    check("rst_done_err", {done, err}, 0);
    check("rst_sel", {alu_and, alu_add, alu_dr0, alu_inpt, alu_com, alu_shl, alu_shr}, 0);
    #2 rst = 1'b0;
    tick();

    // AC=FFFF via LDA, then ADD 1 with ack in the 2nd RD cycle
    run_op(4'd3, 12'h123, 1, 16'hFFFF);
    check("lda_lat", lat, 3);
    check("lda_ac", ac, 16'hFFFF);
    check("lda_sel", sel_seen, S_DR0);
    check("lda_addr_bad", addr_bad, 0);
    run_op(4'd2, 12'h456, 2, 16'h0001);
    check("add_lat", lat, 4);
    check("add_rd_cycles", rd_cycles, 2);
    check("add_ac", ac, 16'h0000);
    check("add_e", e, 1);
    check("add_zero", ac_zero, 1);
    check("add_sel", sel_seen, S_ADD);
    check("add_err", got_err, 0);

    // Rotates
    run_op(4'd3, 12'h001, 1, 16'h0003);
    run_op(4'd5, 12'h000, 0, 16'h0);
    check("cle_lat", lat, 2);
    check("cle_e", e, 0);
    check("cle_ac_kept", ac, 16'h0003);
    run_op(4'd8, 12'h000, 0, 16'h0);
    check("cir_sel", sel_seen, S_SHR);
    check("cir_sel_cycles", sel_cycles, 1);
    check("cir_ac", ac, 16'h0001);
    check("cir_e", e, 1);
    run_op(4'd9, 12'h000, 0, 16'h0);
    check("cil_sel", sel_seen, S_SHL);
    check("cil_ac", ac, 16'h0003);
    check("cil_e", e, 0);

    // Read timeout, then ack exactly on the last allowed cycle
    run_op(4'd3, 12'h7FF, 0, 16'h0);
    check("tmo_rd_cycles", rd_cycles, TMO);
    check("tmo_lat", lat, TMO + 1);
    check("tmo_err", got_err, 1);
    check("tmo_sel", sel_seen, S_NONE);
    check("tmo_ac", ac, 16'h0003);
    run_op(4'd3, 12'h7FE, TMO, 16'h5A5A);
    check("late_ack_lat", lat, TMO + 2);
    check("late_ack_err", got_err, 0);
    check("late_ack_ac", ac, 16'h5A5A);

    // Illegal op
    run_op(4'd13, 12'h000, 0, 16'h0);
    check("ill_lat", lat, 2);
    check("ill_err", got_err, 1);
    check("ill_sel", sel_seen, S_NONE);
    check("ill_ac", ac, 16'h5A5A);
    check("ill_e", e, 0);

    // AND, INP, CLA, NOP
    run_op(4'd1, 12'h010, 1, 16'h0FF0);
    check("and_ac", ac, 16'h0A50);
    check("and_sel", sel_seen, S_AND);
    run_op(4'd11, 12'h000, 0, 16'h0);
    check("inp_ac", ac, 16'h00C3);
    check("inp_ack", inp_cycles, 1);
    check("inp_sel", sel_seen, S_INPT);
    run_op(4'd0, 12'h000, 0, 16'h0);
    check("nop_ac", ac, 16'h00C3);
    check("nop_lat", lat, 2);
    run_op(4'd4, 12'h000, 0, 16'h0);
    check("cla_ac", ac, 16'h0000);
    check("cla_sel", sel_seen, S_NONE);

    // INC (stray mem_ack ignored), CME, CMA issued back to back
    run_op(4'd3, 12'h020, 1, 16'h1234);
    run_op(4'd10, 12'h000, 1, 16'hFFFF);
    check("inc_ac", ac, 16'h1235);
    check("inc_e", e, 0);
    check("inc_lat", lat, 2);
    check("b2b_ready_with_done", {req_ready, done}, 2'b11);
    run_op(4'd7, 12'h000, 0, 16'h0);
    check("cme_lat", lat, 2);
    check("cme_e", e, 1);
    check("cme_ac", ac, 16'h1235);
    run_op(4'd6, 12'h000, 0, 16'h0);
    check("cma_ac", ac, 16'hEDCA);
    check("cma_neg", ac_neg, 1);
    check("cma_sel", sel_seen, S_COM);
    check("cma_onehot", multi, 0);

    // Asynchronous reset in EXEC, then in RD
    req_valid = 1'b1;
    req_op    = 4'd6;
    tick();
    req_valid = 1'b0;
    check("pre_rst_com", alu_com, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_com", alu_com, 0);
    check("arst_ac", ac, 0);
    check("arst_e", e, 0);
    check("arst_ready", req_ready, 1);
    #1 rst = 1'b0;
    tick();
    req_valid = 1'b1;
    req_op    = 4'd3;
    req_addr  = 12'h0AA;
    tick();
    req_valid = 1'b0;
    check("pre_rst_mem_rd", mem_rd, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_mem_rd", mem_rd, 0);
    check("arst_rd_ready", req_ready, 1);
    #1 rst = 1'b0;
    tick();
    tick();
    check("post_rst_idle", {req_ready, mem_rd, done}, 3'b100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
